mc_arch_regs: RTL
=================

Name: mc_arch_regs

Overview:
- Nonarchitectural and PC register slice of the multicycle RISC-V datapath, directly downstream of the multicycle controller.
- Consumes the controller's PCWrite, IRWrite, AdrSrc and ResultSrc.
- Holds PC, OldPC, Instr, Data, A, WriteData and ALUOut.
- Produces the memory address, the Result bus, and the decoded op/funct3/funct7b5 fields that feed back into the controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC and OldPC value after reset.
- RESET_INSTR, 32'h0000_0013, Instr value after reset (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- PCWrite  in  1  load PC from Result
- IRWrite  in  1  load Instr/OldPC
- AdrSrc  in  1  address select: 0=PC, 1=Result
- ResultSrc  in  2  Result select
- ALUResult  in  32  combinational ALU output
- ReadData  in  32  unified memory read data
- RD1  in  32  register file read port 1
- RD2  in  32  register file read port 2
- Adr  out  32  memory address
- PC  out  32  program counter
- OldPC  out  32  PC of the instruction currently in Instr
- Instr  out  32  instruction register
- op  out  7  Instr[6:0]
- funct3  out  3  Instr[14:12]
- funct7b5  out  1  Instr[30]
- rs1  out  5  Instr[19:15]
- rs2  out  5  Instr[24:20]
- rd  out  5  Instr[11:7]
- A  out  32  latched RD1
- WriteData  out  32  latched RD2
- ALUOut  out  32  latched ALUResult
- Data  out  32  latched ReadData
- Result  out  32  result bus
- InstrCount  out  32  fetch counter (see Optional Feature)

Behaviour:
- Clock and reset: all state updates on the rising edge of clk. Reset is synchronous and active-high and dominates every enable.
- Reset values:
  - PC = OldPC = RESET_PC
  - Instr = RESET_INSTR
  - Data = A = WriteData = ALUOut = 0
  - InstrCount = 0
- PC: PC <= Result when PCWrite=1; otherwise it holds.
- Instruction capture: when IRWrite=1, Instr <= ReadData and OldPC <= PC, using the pre-edge PC value. Otherwise both hold.
- Unconditional latches, every non-reset cycle:
  - Data <= ReadData
  - A <= RD1
  - WriteData <= RD2
  - ALUOut <= ALUResult
- Result mux (combinational, zero latency):
  - 00 = ALUOut
  - 01 = Data
  - 10 = ALUResult
  - 11 = 32'h0
- Address mux (combinational): Adr = AdrSrc ? Result : PC.
- Decoded fields: combinational slices of the registered Instr. They change only the cycle after an IRWrite edge, so the controller's decode state always sees stable fields.
- Fetch cycle (PCWrite=1, IRWrite=1, ResultSrc=10): OldPC captures the old PC, PC captures ALUResult (PC+4) and Instr captures ReadData, all on the same edge. There is no read-after-write hazard inside the block.
- PCWrite with ResultSrc=00 (branch/jal target from ALUOut) loads ALUOut as it stood before the edge.
- Reset mid-instruction: all registers return to reset values on the next edge regardless of enables. The decoded op becomes 7'b0010011.
- No internal FSM. The controller owns sequencing; this block is strictly enable-driven.

Optional Feature:
- Macro: MC_INSTRET_EN.
- Defined: InstrCount increments by 1 on every non-reset edge with IRWrite=1, wraps 32'hFFFF_FFFF -> 0, and resets to 0.
- Not defined: no counter logic is built. InstrCount is tied to 32'h0. The port list is identical in both builds.

Test Plan:
- Reset with all enables high and ReadData=32'hDEADBEEF -> next cycle: PC=0, OldPC=0, Instr=32'h13, op=7'b0010011, A=WriteData=ALUOut=Data=0.
- Fetch at PC=32'h10: drive PCWrite=1, IRWrite=1, ResultSrc=10, ALUResult=32'h14, ReadData=32'h00500093 -> after edge: PC=32'h14, OldPC=32'h10, Instr=32'h00500093, op=7'b0010011, rd=1, rs1=0.
- Load writeback: ReadData=32'h0000_00AA, one edge, then ResultSrc=01 -> Data=32'hAA, Result=32'hAA. Set AdrSrc=1 with ResultSrc=00, ALUOut=32'h2004 -> Adr=32'h2004.
- Branch taken: ALUOut=32'h40, ResultSrc=00, PCWrite=1, IRWrite=0 -> PC=32'h40, OldPC and Instr unchanged. With PCWrite=0 -> PC holds.
- ResultSrc=11 -> Result=0. Reset asserted in the same cycle as PCWrite=1 -> PC=RESET_PC, not Result.
- MC_INSTRET_EN defined: 3 IRWrite pulses -> InstrCount=3. Force count to 32'hFFFF_FFFF, apply one IRWrite -> 0. Undefined build -> InstrCount stays 0 throughout.

Source files
------------

// File: rtl/mc_arch_regs.sv
// ---------------------------------------------------------------------------
// mc_arch_regs
//   Nonarchitectural and PC register slice of the multicycle RISC-V datapath.
//   It holds PC, OldPC, Instr, Data, A, WriteData and ALUOut under control of
//   the multicycle controller. It drives the memory address, the Result bus
//   and the decoded instruction fields that go back to the controller.
//   Sequencing belongs to the controller; this block only follows enables.
//
// Optional feature macro: MC_INSTRET_EN
//   defined   : InstrCount counts IRWrite edges (wraps, reset to 0)
//   undefined : no counter is built, InstrCount is tied to 0
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   PCWrite               PC <= Result
//   IRWrite               Instr <= ReadData, OldPC <= PC
//   AdrSrc                Adr select: 0 = PC, 1 = Result
//   ResultSrc[1:0]        Result select: ALUOut / Data / ALUResult / 0
//   ALUResult, ReadData   ALU output and memory read data
//   RD1, RD2              register file read ports
//   Adr, Result           memory address and result bus
//   PC, OldPC, Instr      architectural-facing registers
//   op..rd                slices of Instr
//   A, WriteData, ALUOut, Data   per-cycle latches
//   InstrCount            fetch counter
// ---------------------------------------------------------------------------
module mc_arch_regs #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic [1:0]  ResultSrc,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic [31:0] Adr,
  output logic [31:0] PC,
  output logic [31:0] OldPC,
  output logic [31:0] Instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] A,
  output logic [31:0] WriteData,
  output logic [31:0] ALUOut,
  output logic [31:0] Data,
  output logic [31:0] Result,
  output logic [31:0] InstrCount
);

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  logic [31:0] r_pc;
  logic [31:0] r_old_pc;
  logic [31:0] r_instr;
  logic [31:0] r_data;
  logic [31:0] r_a;
  logic [31:0] r_wd;
  logic [31:0] r_alu_out;
  logic [31:0] w_result;

  // Result uses only pre-edge register values, so a PCWrite from ALUOut
  // picks up the target computed in the previous cycle.
  always_comb begin
    w_result = 32'h0;
    case (ResultSrc)
      RES_ALUOUT: w_result = r_alu_out;
      RES_DATA:   w_result = r_data;
      RES_ALURES: w_result = ALUResult;
      default:    w_result = 32'h0;
    endcase
  end

  // PC and instruction capture. OldPC takes r_pc before this edge updates it,
  // so a fetch that writes PC and Instr together stays consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_old_pc <= RESET_PC;
      r_instr  <= RESET_INSTR;
    end else begin
      if (PCWrite) r_pc <= w_result;
      if (IRWrite) begin
        r_instr  <= ReadData;
        r_old_pc <= r_pc;
      end
    end
  end

  // Per-cycle latches that break the multicycle paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= 32'h0;
      r_a       <= 32'h0;
      r_wd      <= 32'h0;
      r_alu_out <= 32'h0;
    end else begin
      r_data    <= ReadData;
      r_a       <= RD1;
      r_wd      <= RD2;
      r_alu_out <= ALUResult;
    end
  end

`ifdef MC_INSTRET_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (reset)        r_instr_count <= 32'h0;
    else if (IRWrite) r_instr_count <= r_instr_count + 32'd1;
  end

  assign InstrCount = r_instr_count;
`else
  assign InstrCount = 32'h0;
`endif

  assign Result    = w_result;
  assign Adr       = AdrSrc ? w_result : r_pc;
  assign PC        = r_pc;
  assign OldPC     = r_old_pc;
  assign Instr     = r_instr;
  assign Data      = r_data;
  assign A         = r_a;
  assign WriteData = r_wd;
  assign ALUOut    = r_alu_out;

  // Fields come from the registered Instr, so they only move after an
  // IRWrite edge and are stable through decode.
  assign op       = r_instr[6:0];
  assign rd       = r_instr[11:7];
  assign funct3   = r_instr[14:12];
  assign rs1      = r_instr[19:15];
  assign rs2      = r_instr[24:20];
  assign funct7b5 = r_instr[30];

endmodule
